result_reader: RTL and testbench
================================

# result_reader

Reads a finished convolution output feature map back out of the result memory and streams it as signed int8 beats over a valid/ready interface. Addressing is channel-major: kernel 0 words 0..N-1, then kernel 1, and so on. It sits on the read port of the result memory, on the opposite side from the result writer. It is started by the writer's `w_done` pulse, or by a controller that forwards that pulse. Downstream consumers are the next layer's input loader or the host readback DMA.

## Interface
Parameters:
- `ADDR_W`, default 16: result memory address width.
- `DATA_W`, default 8: result word width (signed).
- `CNT_W`, default 16: width of the feature-size and kernel-count inputs.

Ports (reset is asynchronous and active-low; one clock):
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a readback. Ignored while `busy`=1.
- `base_addr` in ADDR_W: address of kernel 0, word 0. Sampled on `start`.
- `o_feature_size` in CNT_W: words per kernel channel (N). Sampled on `start`.
- `kernel_num` in CNT_W: number of channels (K). Sampled on `start`.
- `rd_ena` out 1: memory read enable.
- `rd_addr` out ADDR_W: memory read address.
- `rd_data` in DATA_W: memory read data, valid exactly 1 cycle after `rd_ena`.
- `m_data` out DATA_W: signed output beat.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accept.
- `m_last_ch` out 1: beat is the last word of the current channel.
- `m_last` out 1: beat is the last word of the whole map.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: on `start`, latch the inputs. If N=0 or K=0, go to FIN. Otherwise zero the word and channel counters, set address = `base_addr`, and go to READ.
  - READ: issue reads. After the read of word (K-1, N-1) is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to FIN.
  - FIN: pulse `done` and go to IDLE.
- Address generation:
  - The address increments by 1 per issued read. Channels are contiguous, so channel c word i is at `base_addr` + c·N + i.
  - The address wraps modulo 2^ADDR_W.
  - The word counter wraps to 0 at N-1. The channel counter increments on each word-counter wrap.
- Output buffer:
  - 2-entry FIFO holding {data, last_ch, last}. Tags are computed at issue time and pipelined with the 1-cycle read.
  - Credit rule: issue a read only when occupancy + in-flight − (pop this cycle) < 2. The FIFO therefore never overflows and never needs memory back-pressure.
- Handshake:
  - A beat transfers when `m_valid`=1 and `m_ready`=1.
  - While `m_ready`=0, `m_data`, `m_last_ch` and `m_last` are held stable.
  - `m_valid` never drops without a transfer.
- Edge cases:
  - `start` during `busy` is ignored and does not re-latch the inputs.
  - `start` in the FIN cycle is also ignored.
  - Reset mid-operation clears state, the FIFO, the counters and the in-flight flag immediately. No beat or `done` follows.

## Timing
- Reset values: `rd_ena`=0, `rd_addr`=0, `m_data`=0, `m_valid`=0, `m_last_ch`=0, `m_last`=0, `busy`=0, `done`=0.
- `start` in cycle T: `busy`=1 and first `rd_ena` (`rd_addr`=`base_addr`) in cycle T+1. The first `m_valid` is in T+2.
- With `m_ready` held at 1, throughput is 1 beat per cycle. The last beat appears at T+1+N·K, and `done` pulses in the cycle after the last handshake.
- `busy` falls in the same cycle that `done` is high, so `busy` and `done` are never both 1.
- When N=0 or K=0, `done` pulses at T+1 and no `rd_ena` is issued.
- Latency from a `m_ready` rise to a transfer is 0 cycles if the FIFO holds data.

## Configuration
- `RESULT_READ_RELU_EN`:
  - Defined: `m_data` = max(`rd_data`, 0) in signed terms, so −128..−1 become 0. Applied at FIFO write.
  - Undefined: `m_data` = `rd_data` unchanged.
- Tags, timing and addressing are identical either way.

## Test plan
- Reset: assert `rstn`=0 mid-stream at beat 5 of N=4, K=3. All outputs are 0 next cycle, and no `done` follows.
- Basic: `base_addr`=0x0100, N=4, K=3, `m_ready`=1, memory word at address a = a[7:0]. Expect 12 beats 0x00..0x0B on consecutive cycles, `m_last_ch` on beats 3, 7 and 11, `m_last` on beat 11 only, and `done` 1 cycle after beat 11.
- Back-pressure: same setup with `m_ready` toggled 1,0,0,1 repeatedly. Expect the same 12-beat sequence, held data while `m_ready`=0, and `rd_ena` never issued while 2 entries are committed.
- Zero size: N=0, K=5. Expect `done` at T+1, no `rd_ena` and no `m_valid`. Repeat with N=7, K=0 and expect the same.
- Wrap: `base_addr`=0xFFFE, N=3, K=1. Expect `rd_addr` 0xFFFE, 0xFFFF, 0x0000. A `start` pulsed mid-run is ignored.
- ReLU: memory holds −3, 0, 5, −128 with N=4, K=1. With `RESULT_READ_RELU_EN` defined, expect 0, 0, 5, 0. Without it, expect −3, 0, 5, −128.

Source files
------------

// File: rtl/result_reader.sv
// Streams a channel-major result feature map out of the result memory as int8 beats.
// Optional build macro RESULT_READ_RELU_EN clamps negative words to zero on FIFO write.
module result_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  o_feature_size,
    input  logic [CNT_W-1:0]  kernel_num,
    output logic              rd_ena,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last_ch,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  feat_n;
    logic [CNT_W-1:0]  kern_k;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  ch_cnt;

    logic              tag_v;
    logic              tag_last_ch;
    logic              tag_last;

    logic [DATA_W-1:0] fifo_data [0:1];
    logic              fifo_lch  [0:1];
    logic              fifo_last [0:1];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;

    logic [DATA_W-1:0] in_data;
    logic              pop;
    logic              fifo_pop;
    logic              push;
    logic              credit_ok;
    logic              word_last;
    logic              chan_last;
    logic              cur_last;

    always_comb begin
`ifdef RESULT_READ_RELU_EN
        in_data = rd_data[DATA_W-1] ? '0 : rd_data;
`else
        in_data = rd_data;
`endif
    end

    // Returning read data bypasses the FIFO when it is empty, so the first beat
    // appears in the same cycle its read data does.
    always_comb begin
        m_valid   = (count != 2'd0) || tag_v;
        m_data    = '0;
        m_last_ch = 1'b0;
        m_last    = 1'b0;
        if (count != 2'd0) begin
            m_data    = fifo_data[rd_ptr];
            m_last_ch = fifo_lch[rd_ptr];
            m_last    = fifo_last[rd_ptr];
        end else if (tag_v) begin
            m_data    = in_data;
            m_last_ch = tag_last_ch;
            m_last    = tag_last;
        end
    end

    always_comb begin
        pop        = m_valid && m_ready;
        fifo_pop   = pop && (count != 2'd0);
        push       = tag_v && !(pop && (count == 2'd0));
        count_next = count + {1'b0, push} - {1'b0, fifo_pop};
        credit_ok  = (count_next + {1'b0, rd_ena}) < 2'd2;
        word_last  = (word_cnt == feat_n - CNT_W'(1));
        chan_last  = (ch_cnt == kern_k - CNT_W'(1));
        cur_last   = word_last && chan_last;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v        <= 1'b0;
            tag_last_ch  <= 1'b0;
            tag_last     <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_lch[0]  <= 1'b0;
            fifo_lch[1]  <= 1'b0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
        end else begin
            tag_v <= rd_ena;
            if (rd_ena) begin
                tag_last_ch <= word_last;
                tag_last    <= cur_last;
            end
            if (push) begin
                fifo_data[wr_ptr] <= in_data;
                fifo_lch[wr_ptr]  <= tag_last_ch;
                fifo_last[wr_ptr] <= tag_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

    // Counters always name the word currently at rd_addr; the word is issued in
    // the cycle rd_ena is first seen with it, so READ exits right after the last issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rd_ena   <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            feat_n   <= '0;
            kern_k   <= '0;
            word_cnt <= '0;
            ch_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        feat_n <= o_feature_size;
                        kern_k <= kernel_num;
                        if ((o_feature_size == '0) || (kernel_num == '0)) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            word_cnt <= '0;
                            ch_cnt   <= '0;
                            rd_addr  <= base_addr;
                            rd_ena   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_ena && cur_last) begin
                        rd_ena <= 1'b0;
                        state  <= DRAIN;
                    end else if (credit_ok) begin
                        rd_ena  <= 1'b1;
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (word_last) begin
                            word_cnt <= '0;
                            ch_cnt   <= ch_cnt + CNT_W'(1);
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end else begin
                        rd_ena <= 1'b0;
                    end
                end
                DRAIN: begin
                    if ((count_next == 2'd0) && !rd_ena) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// Directed and randomized readback jobs for result_reader, checked against a
// queue-based model of the channel-major map built from the memory contents.
module tb_result_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] o_feature_size = '0;
    logic [15:0] kernel_num = '0;
    logic        rd_ena;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last_ch;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    int          passes = 0;
    int          fails = 0;
    int          total = 0;

    result_reader #(
        .ADDR_W(16),
        .DATA_W(8),
        .CNT_W (16)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .base_addr     (base_addr),
        .o_feature_size(o_feature_size),
        .kernel_num    (kernel_num),
        .rd_ena        (rd_ena),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last_ch     (m_last_ch),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Synchronous read memory: data valid one cycle after rd_ena.
    always @(posedge clk) begin
        if (rd_ena) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_beat(input logic [7:0] raw);
`ifdef RESULT_READ_RELU_EN
        return ($signed(raw) < 0) ? 8'd0 : raw;
`else
        return raw;
`endif
    endfunction

    function automatic logic ready_for(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 4 == 0) || (t % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_ena"}, rd_ena, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last_ch"}, m_last_ch, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
    // abort_at >= 0 pulls reset once that many beats have transferred.
    task automatic run_job(input logic [15:0] base, input logic [15:0] n, input logic [15:0] k,
                           input int mode, input bit mid_start, input int abort_at);
        logic [7:0]  q_data [$];
        logic        q_lch [$];
        logic        q_last [$];
        logic [15:0] q_addr [$];
        int          total_beats;
        int          issued;
        int          xfers;
        int          bad;
        bit          seen_done;
        logic        prev_stall;
        logic [9:0]  prev_beat;

        total_beats = int'(n) * int'(k);
        issued = 0;
        xfers = 0;
        seen_done = 1'b0;
        prev_stall = 1'b0;
        prev_beat = '0;
        for (int c = 0; c < int'(k); c++) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [15:0] a;
                a = 16'(int'(base) + c * int'(n) + i);
                q_addr.push_back(a);
                q_data.push_back(ref_beat(mem[a]));
                q_lch.push_back(i == int'(n) - 1);
                q_last.push_back((i == int'(n) - 1) && (c == int'(k) - 1));
            end
        end

        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        o_feature_size = n;
        kernel_num = k;
        m_ready = ready_for(mode, 0);
        #1;
        check("idle_busy", busy, 0);

        for (int t = 1; t <= 400; t++) begin
            @(posedge clk); #1;
            start = mid_start && (t == 2);
            base_addr = 16'($urandom());
            o_feature_size = 16'($urandom());
            kernel_num = 16'($urandom());
            m_ready = ready_for(mode, t);
            #1;
            if (abort_at >= 0 && xfers == abort_at) begin
                rstn = 1'b0;
                #1;
                check_all_zero("abort");
                start = 1'b0;
                @(posedge clk); #1;
                rstn = 1'b1;
                bad = 0;
                for (int w = 0; w < 20; w++) begin
                    @(posedge clk); #2;
                    if (done || m_valid || rd_ena || busy) bad++;
                end
                check("post_reset_quiet", bad, 0);
                return;
            end
            if (t == 1) begin
                check("busy_t1", busy, total_beats != 0);
                check("rd_ena_t1", rd_ena, total_beats != 0);
                if (total_beats != 0) check("first_addr", rd_addr, base);
            end
            if (t == 2 && total_beats != 0) check("first_valid", m_valid, 1);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_beat", {m_data, m_last_ch, m_last}, prev_beat);
            end
            if (rd_ena) begin
                check("credit", (issued - xfers) < 2, 1);
                check("read_in_range", issued < total_beats, 1);
                if (issued < total_beats) check("rd_addr", rd_addr, q_addr[issued]);
                issued++;
            end
            check("busy_done_excl", busy && done, 0);
            if (m_valid && m_ready) begin
                check("beat_in_range", xfers < total_beats, 1);
                if (xfers < total_beats) begin
                    check("beat_data", m_data, q_data[xfers]);
                    check("beat_last_ch", m_last_ch, q_lch[xfers]);
                    check("beat_last", m_last, q_last[xfers]);
                    if (mode == 0) check("beat_time", t, xfers + 2);
                end
                xfers++;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat = {m_data, m_last_ch, m_last};
            if (done) begin
                check("done_beats", xfers, total_beats);
                check("done_reads", issued, total_beats);
                if (mode == 0) check("done_time", t, (total_beats == 0) ? 1 : total_beats + 2);
                seen_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        if (seen_done) begin
            @(posedge clk); #2;
            check("done_pulse_end", done, 0);
            check("busy_after", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rb;
        logic [15:0] rn;
        logic [15:0] rk;

        for (int a = 0; a < 65536; a++) mem[a] = 8'(a);

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rstn = 1'b1;

        run_job(16'h0100, 16'd4, 16'd3, 0, 1'b0, -1);
        run_job(16'h0100, 16'd4, 16'd3, 1, 1'b0, -1);
        run_job(16'h0000, 16'd0, 16'd5, 0, 1'b0, -1);
        run_job(16'h0040, 16'd7, 16'd0, 0, 1'b0, -1);
        run_job(16'hFFFE, 16'd3, 16'd1, 0, 1'b1, -1);

        mem[16'h2000] = 8'hFD;
        mem[16'h2001] = 8'h00;
        mem[16'h2002] = 8'h05;
        mem[16'h2003] = 8'h80;
        run_job(16'h2000, 16'd4, 16'd1, 0, 1'b0, -1);

        run_job(16'h0100, 16'd4, 16'd3, 0, 1'b0, 5);
        run_job(16'h0100, 16'd4, 16'd3, 0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            rb = 16'($urandom());
            rn = 16'($urandom_range(1, 6));
            rk = 16'($urandom_range(1, 4));
            for (int j = 0; j < int'(rn) * int'(rk); j++) mem[16'(int'(rb) + j)] = 8'($urandom());
            run_job(rb, rn, rk, 2, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
